// File: rtl/univ_shift_reg.sv
// Parametrised universal register with a built-in full-duplex serial transfer engine.
// Idle cycles apply the per-cycle op; a start loads din and shifts WIDTH bits out of
// sout while capturing WIDTH bits from sin, reporting busy and a one-cycle done pulse.
module univ_shift_reg #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROTL  = 3'b100;
  localparam logic [2:0] OP_ROTR  = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] xfer_shift;

  // Transfer shift moves toward sout and pulls sin in at the opposite end.
  always_comb begin
    if (MSB_FIRST) xfer_shift = {q_q[WIDTH-2:0], sin};
    else           xfer_shift = {sin, q_q[WIDTH-1:1]};
  end

  // Next-state: abort beats a transfer shift, a shift beats start, start beats op.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (en) begin
      if (busy_q) begin
        if (op == OP_CLEAR) begin
          q_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b0;
        end else begin
          q_d   = xfer_shift;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end else if (start) begin
        q_d    = din;
        cnt_d  = CW'(WIDTH);
        busy_d = 1'b1;
      end else begin
        case (op)
          OP_HOLD:  q_d = q_q;
          OP_LOAD:  q_d = din;
          OP_SHL:   q_d = {q_q[WIDTH-2:0], sin};
          OP_SHR:   q_d = {sin, q_q[WIDTH-1:1]};
          OP_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          OP_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
          OP_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          OP_CLEAR: q_d = '0;
          default:  q_d = q_q;
        endcase
      end
    end
  end

  // State registers with synchronous reset; reset mid-transfer drops any pending done.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Outputs straight from the registers; sout taps the end facing the link.
  always_comb begin
    q    = q_q;
    busy = busy_q;
    done = done_q;
    sout = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg at WIDTH=8, both transfer directions side by side.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] din = 8'h00;
  logic       sin = 1'b0;
  logic       start = 1'b0;

  logic [7:0] q_m, q_l;
  logic       sout_m, sout_l, busy_m, busy_l, done_m, done_l;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state, index 0 = MSB-first, 1 = LSB-first
  bit [7:0] m_q[2];
  bit       m_busy[2];
  bit       m_done[2];
  int       m_left[2];

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .en(en), .op(op), .din(din), .sin(sin), .start(start),
    .q(q_m), .sout(sout_m), .busy(busy_m), .done(done_m));

  univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .en(en), .op(op), .din(din), .sin(sin), .start(start),
    .q(q_l), .sout(sout_l), .busy(busy_l), .done(done_l));

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [7:0] din;
    logic       sin;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model advanced with the inputs present at the coming edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 1'b0;
      if (rst) begin
        m_q[d] = 8'h00; m_busy[d] = 1'b0; m_left[d] = 0;
      end else if (en) begin
        if (m_busy[d]) begin
          if (op == 3'd7) begin
            m_q[d] = 8'h00; m_busy[d] = 1'b0; m_left[d] = 0;
          end else begin
            if (d == 0) m_q[d] = (m_q[d] << 1) | 8'(sin);
            else        m_q[d] = (m_q[d] >> 1) | (8'(sin) << 7);
            m_left[d] = m_left[d] - 1;
            if (m_left[d] == 0) begin
              m_busy[d] = 1'b0; m_done[d] = 1'b1;
            end
          end
        end else if (start) begin
          m_q[d] = din; m_busy[d] = 1'b1; m_left[d] = 8;
        end else begin
          case (op)
            3'd1: m_q[d] = din;
            3'd2: m_q[d] = (m_q[d] << 1) | 8'(sin);
            3'd3: m_q[d] = (m_q[d] >> 1) | (8'(sin) << 7);
            3'd4: m_q[d] = (m_q[d] << 1) | (m_q[d] >> 7);
            3'd5: m_q[d] = (m_q[d] >> 1) | (m_q[d] << 7);
            3'd6: m_q[d] = (m_q[d] >> 1) | (m_q[d] & 8'h80);
            3'd7: m_q[d] = 8'h00;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("m_q", q_m, m_q[0]);
    chk("m_busy", busy_m, m_busy[0]);
    chk("m_done", done_m, m_done[0]);
    chk("m_sout", sout_m, m_q[0][7]);
    chk("l_q", q_l, m_q[1]);
    chk("l_busy", busy_l, m_busy[1]);
    chk("l_done", done_l, m_done[1]);
    chk("l_sout", sout_l, m_q[1][0]);
  endtask

  task automatic set_idle();
    rst = 1'b0; en = 1'b1; op = 3'd0; start = 1'b0; sin = 1'b0; din = 8'h00;
  endtask

  initial begin
    logic [7:0] tx;
    logic [7:0] rx;

    vecs[0]  = '{1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'hA5};
    vecs[3]  = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 8'h81};
    vecs[6]  = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 8'h03};
    vecs[7]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'h81};
    vecs[8]  = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 8'hC0};
    vecs[9]  = '{1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 8'h81};
    vecs[10] = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 8'h03};
    vecs[11] = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 8'h81};
    vecs[12] = '{1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 3'd1, 8'hFF, 1'b0, 8'h00};

    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; op = vecs[i].op;
      din = vecs[i].din; sin = vecs[i].sin; start = 1'b0;
      step();
      chk($sformatf("vec%0d_q", i), q_m, vecs[i].exp_q);
    end
    chk("reset_busy", busy_m, 0);

    // full transfer: din B4 out, 1,0,0,1,1,1,0,0 in
    set_idle();
    tx = 8'hB4; rx = 8'h9C;
    din = tx; start = 1'b1;
    step();
    start = 1'b0; din = 8'h00;
    for (int k = 0; k < 8; k++) begin
      chk("xfer_sout_m", sout_m, tx[7-k]);
      chk("xfer_sout_l", sout_l, tx[k]);
      chk("xfer_busy", busy_m, 1);
      chk("xfer_nodone", done_m, 0);
      sin = rx[7-k];
      step();
    end
    chk("xfer_done", done_m, 1);
    chk("xfer_busy_end", busy_m, 0);
    chk("xfer_q_m", q_m, 8'h9C);
    chk("xfer_q_l", q_l, 8'h39);
    sin = 1'b0;
    step();
    chk("xfer_done_pulse", done_m, 0);

    // stall for 3 cycles mid-word
    set_idle();
    din = 8'h5A; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_q", q_m, 8'hD0);
      chk("stall_sout", sout_m, 1);
      chk("stall_busy", busy_m, 1);
      chk("stall_done", done_m, 0);
    end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_done_t", done_m, (k == 4) ? 1 : 0);
    end
    chk("stall_q_end", q_m, 8'h00);

    // start while busy is ignored
    set_idle();
    tx = 8'hB4;
    din = tx; start = 1'b1; sin = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("restart_sout", sout_m, tx[7-k]);
      start = (k >= 2 && k < 5);
      din = 8'h0F;
      step();
    end
    start = 1'b0;
    chk("restart_done", done_m, 1);
    chk("restart_q", q_m, 8'hFF);

    // abort at shift 4
    set_idle();
    din = 8'hA5; start = 1'b1; sin = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    op = 3'd7;
    step();
    chk("abort_q", q_m, 0);
    chk("abort_busy", busy_m, 0);
    op = 3'd0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_nodone", done_m, 0);
    end

    // reset at shift 5, then a clean transfer
    set_idle();
    din = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    chk("rst_q", q_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    rst = 1'b0; din = 8'hC3; start = 1'b1;
    step();
    start = 1'b0; sin = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rst_new_done", done_m, (k == 7) ? 1 : 0);
    end
    chk("rst_new_q", q_m, 8'hFF);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 9) != 0);
      op    = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      start = ($urandom_range(0, 5) == 0);
      din   = 8'($urandom);
      sin   = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
